// File: rtl/dds_wavegen.sv
// ---------------------------------------------------------------------------
// dds_wavegen -- direct digital synthesis waveform generator
//
// A phase accumulator advances by a frequency word on every enabled cycle.
// A three-stage pipeline turns the accumulator value into one output sample:
//   stage 1  phase = acc + phase offset
//   stage 2  waveform lookup or compute (sine ROM, square, triangle, saw, noise)
//   stage 3  attenuation by a logical right shift
// An acc value registered at cycle n appears on out_data at cycle n+3.
//
// Optional feature macro: DDS_WAVEGEN_NOISE_EN
//   When this macro is defined, cfg_wave=4 selects a 16-bit Fibonacci LFSR
//   (taps 16,14,13,11) that steps once per enabled cycle. When it is
//   undefined, no LFSR exists and cfg_wave=4 outputs 0.
//   The noise path takes the top DATA_W LFSR bits, so it needs DATA_W <= 16.
//
// Parameters
//   DATA_W  sample width of out_data
//   ACC_W   phase accumulator / fword / pword width (>= LUT_AW+1, >= DATA_W+1)
//   LUT_AW  sine ROM address width (2^LUT_AW entries)
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst_n          synchronous active-low reset
//   enable         accumulator advances and samples enter the pipeline
//   cfg_load       one-cycle strobe latching all cfg_* inputs
//   cfg_clr        with cfg_load, clears the accumulator to 0
//   cfg_wave       0 sine, 1 square, 2 triangle, 3 saw, 4 noise, 5-7 zero
//   cfg_fword      frequency word
//   cfg_pword      phase offset word
//   cfg_duty       square wave high threshold (top 8 phase bits < duty)
//   cfg_amp_shift  attenuation as a logical right shift
//   out_data       output sample (offset binary for sine)
//   out_valid      out_data holds a new sample this cycle
//   wrap           one-cycle pulse after the accumulator overflows
// ---------------------------------------------------------------------------
module dds_wavegen #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int LUT_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              cfg_load,
    input  logic              cfg_clr,
    input  logic [2:0]        cfg_wave,
    input  logic [ACC_W-1:0]  cfg_fword,
    input  logic [ACC_W-1:0]  cfg_pword,
    input  logic [7:0]        cfg_duty,
    input  logic [2:0]        cfg_amp_shift,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              wrap
);

    localparam logic [2:0] WAVE_SINE     = 3'd0;
    localparam logic [2:0] WAVE_SQUARE   = 3'd1;
    localparam logic [2:0] WAVE_TRIANGLE = 3'd2;
    localparam logic [2:0] WAVE_SAW      = 3'd3;
`ifdef DDS_WAVEGEN_NOISE_EN
    localparam logic [2:0] WAVE_NOISE    = 3'd4;
`endif

    localparam int LUT_N = 1 << LUT_AW;

    // Fixed-point format used only while building the sine table.
    localparam int     FRAC  = 28;
    localparam longint ONE_Q = longint'(1) <<< FRAC;
    localparam longint PI_Q  = 64'sd843314857;   // round(pi * 2^28)

    // -----------------------------------------------------------------------
    // Sine table entry, evaluated at elaboration time.
    // The angle is folded into the first quadrant, sin() is evaluated with a
    // Taylor series up to x^15 (error far below one LSB), then scaled,
    // rounded half away from zero and offset to mid-scale.
    // -----------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] sine_entry(input int idx);
        int                k;
        int                fold;
        logic              neg;
        longint            x;
        longint            x2;
        longint            term;
        longint            s;
        longint            amp;
        longint            mag;
        logic [DATA_W-1:0] res;
        neg  = (idx >= LUT_N / 2);
        fold = idx % (LUT_N / 2);
        if (fold > LUT_N / 4)
            fold = LUT_N / 2 - fold;
        x    = (PI_Q * longint'(fold)) / longint'(LUT_N / 2);
        x2   = (x * x) >>> FRAC;
        term = x;
        s    = x;
        for (k = 1; k <= 7; k++) begin
            term = (term * x2) >>> FRAC;
            term = -(term / longint'((2 * k) * (2 * k + 1)));
            s    = s + term;
        end
        if (s > ONE_Q)
            s = ONE_Q;
        if (s < 0)
            s = 0;
        amp = (longint'(1) <<< (DATA_W - 1)) - 1;
        mag = (amp * s + (ONE_Q >>> 1)) >>> FRAC;
        if (neg)
            res = DATA_W'((amp + 1) - mag);
        else
            res = DATA_W'((amp + 1) + mag);
        return res;
    endfunction

    // Sine ROM: constant array read through a register in stage 2.
    logic [DATA_W-1:0] sine_rom [LUT_N];

    generate
        for (genvar gi = 0; gi < LUT_N; gi++) begin : g_sine_rom
            localparam logic [DATA_W-1:0] ENTRY = sine_entry(gi);
            assign sine_rom[gi] = ENTRY;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Configuration registers
    // -----------------------------------------------------------------------
    logic [2:0]       cfg_wave_reg;
    logic [ACC_W-1:0] cfg_fword_reg;
    logic [ACC_W-1:0] cfg_pword_reg;
    logic [7:0]       cfg_duty_reg;
    logic [2:0]       cfg_amp_shift_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_wave_reg      <= WAVE_SINE;
            cfg_fword_reg     <= ACC_W'(1);
            cfg_pword_reg     <= '0;
            cfg_duty_reg      <= 8'h80;
            cfg_amp_shift_reg <= 3'd0;
        end else if (cfg_load) begin
            cfg_wave_reg      <= cfg_wave;
            cfg_fword_reg     <= cfg_fword;
            cfg_pword_reg     <= cfg_pword;
            cfg_duty_reg      <= cfg_duty;
            cfg_amp_shift_reg <= cfg_amp_shift;
        end
    end

    // -----------------------------------------------------------------------
    // Phase accumulator and wrap pulse
    // -----------------------------------------------------------------------
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W:0]   acc_sum;
    logic             wrap_reg;

    // One extra bit catches the carry out of the top accumulator bit.
    assign acc_sum = {1'b0, acc_reg} + {1'b0, cfg_fword_reg};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            wrap_reg <= 1'b0;
        end else if (cfg_load && cfg_clr) begin
            // A clear is an explicit request for a phase restart, so it wins
            // over the addition and is honoured even while idle.
            acc_reg  <= '0;
            wrap_reg <= 1'b0;
        end else if (enable) begin
            acc_reg  <= acc_sum[ACC_W-1:0];
            wrap_reg <= acc_sum[ACC_W];
        end else begin
            wrap_reg <= 1'b0;
        end
    end

`ifdef DDS_WAVEGEN_NOISE_EN
    // -----------------------------------------------------------------------
    // Noise source: Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1
    // -----------------------------------------------------------------------
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (!rst_n)
            lfsr_reg <= 16'hACE1;
        else if (enable)
            lfsr_reg <= {lfsr_reg[14:0],
                         lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
`endif

    // -----------------------------------------------------------------------
    // Stage 1: phase offset
    // -----------------------------------------------------------------------
    logic [ACC_W-1:0] ph_reg;
    logic             v1_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_reg <= '0;
            v1_reg <= 1'b0;
        end else begin
            ph_reg <= acc_reg + cfg_pword_reg;
            v1_reg <= enable;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: waveform generation
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] wave_next;
    logic [DATA_W-1:0] wave_reg;
    logic              v2_reg;
    logic [DATA_W-1:0] tri_bits;

    assign tri_bits = ph_reg[ACC_W-2 -: DATA_W];

    always_comb begin
        wave_next = '0;
        case (cfg_wave_reg)
            WAVE_SINE:     wave_next = sine_rom[ph_reg[ACC_W-1 -: LUT_AW]];
            WAVE_SQUARE:   wave_next = (ph_reg[ACC_W-1 -: 8] < cfg_duty_reg) ?
                                       {DATA_W{1'b1}} : '0;
            // Rising half uses the phase below the MSB, falling half mirrors it.
            WAVE_TRIANGLE: wave_next = ph_reg[ACC_W-1] ? ~tri_bits : tri_bits;
            WAVE_SAW:      wave_next = ph_reg[ACC_W-1 -: DATA_W];
`ifdef DDS_WAVEGEN_NOISE_EN
            WAVE_NOISE:    wave_next = lfsr_reg[15 -: DATA_W];
`endif
            default:       wave_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wave_reg <= '0;
            v2_reg   <= 1'b0;
        end else begin
            wave_reg <= wave_next;
            v2_reg   <= v1_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3: attenuation; out_data only changes on a valid sample so it
    // holds its last value while the pipeline is drained.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (v2_reg)
                out_data_reg <= wave_reg >> cfg_amp_shift_reg;
            out_valid_reg <= v2_reg;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign wrap      = wrap_reg;

    // Low phase bits are not needed by every waveform; fold them here so the
    // full phase register is visibly consumed.
    logic unused_ph_bits;
    assign unused_ph_bits = ^ph_reg;

endmodule

// File: tb/tb_dds_wavegen.sv
// ---------------------------------------------------------------------------
// tb_dds_wavegen -- directed self-checking bench for dds_wavegen
// (DATA_W=8, ACC_W=16, LUT_AW=8). Inputs change and outputs are sampled 1 ns
// after each rising clock edge. Expected values are hand-derived per scenario.
// ---------------------------------------------------------------------------
module tb_dds_wavegen;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int LUT_AW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              cfg_load;
    logic              cfg_clr;
    logic [2:0]        cfg_wave;
    logic [ACC_W-1:0]  cfg_fword;
    logic [ACC_W-1:0]  cfg_pword;
    logic [7:0]        cfg_duty;
    logic [2:0]        cfg_amp_shift;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              wrap;

    int n_asserts  = 0;
    int n_failures = 0;

    always #5 clk = ~clk;

    dds_wavegen #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .LUT_AW (LUT_AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .cfg_load      (cfg_load),
        .cfg_clr       (cfg_clr),
        .cfg_wave      (cfg_wave),
        .cfg_fword     (cfg_fword),
        .cfg_pword     (cfg_pword),
        .cfg_duty      (cfg_duty),
        .cfg_amp_shift (cfg_amp_shift),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .wrap          (wrap)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        if (obs !== expv) begin
            n_failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        cfg_load = 1'b0;
        cfg_clr  = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic load_cfg(input logic clr, input logic [2:0] wave, input logic [15:0] fword,
                            input logic [15:0] pword, input logic [7:0] duty,
                            input logic [2:0] shift);
        cfg_clr       = clr;
        cfg_wave      = wave;
        cfg_fword     = fword;
        cfg_pword     = pword;
        cfg_duty      = duty;
        cfg_amp_shift = shift;
        cfg_load      = 1'b1;
        step(1);
        cfg_load = 1'b0;
        cfg_clr  = 1'b0;
    endtask

    // Sample number idx of a 256-sample period, before attenuation.
    function automatic int exp_wave(input int wave, input int idx, input int duty);
        case (wave)
            1:       return (idx < duty) ? 255 : 0;
            2:       return (idx < 128) ? 2 * idx : 255 - 2 * (idx - 128);
            3:       return idx;
            default: return 0;
        endcase
    endfunction

    task automatic run_sweep(input string tag, input int wave, input int duty, input int shift,
                             input int nsamp, output int max_seen);
        int expv;
        max_seen = 0;
        do_reset();
        load_cfg(1'b1, 3'(wave), 16'h0100, 16'h0000, 8'(duty), 3'(shift));
        enable = 1'b1;
        step(3);
        for (int i = 0; i < nsamp; i++) begin
            expv = exp_wave(wave, i % 256, duty) >> shift;
            check_eq({tag, "_data"}, 32'(out_data), 32'(expv));
            check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
            if (int'(out_data) > max_seen)
                max_seen = int'(out_data);
            step(1);
        end
        enable = 1'b0;
        $display("[%s] %0d samples checked, peak %0d", tag, nsamp, max_seen);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int peak;
        int k_last;
        cfg_wave      = 3'd0;
        cfg_fword     = '0;
        cfg_pword     = '0;
        cfg_duty      = '0;
        cfg_amp_shift = '0;

        // Reset state
        do_reset();
        check_eq("reset_data", 32'(out_data), 32'd0);
        check_eq("reset_valid", 32'(out_valid), 32'd0);
        check_eq("reset_wrap", 32'(wrap), 32'd0);
        $display("[reset] outputs idle after reset");

        // Saw ramp, wrap every 256 cycles
        load_cfg(1'b1, 3'd3, 16'h0100, 16'h0000, 8'h80, 3'd0);
        enable = 1'b1;
        k_last = 515;
        for (int k = 1; k <= k_last; k++) begin
            step(1);
            if (k >= 3) begin
                check_eq("saw_data", 32'(out_data), 32'((k - 3) % 256));
                check_eq("saw_valid", 32'(out_valid), 32'd1);
            end else begin
                check_eq("saw_fill_valid", 32'(out_valid), 32'd0);
            end
            check_eq("saw_wrap", 32'(wrap), (k % 256 == 0) ? 32'd1 : 32'd0);
        end
        $display("[saw] %0d cycles checked", k_last);

        // Drain: out_valid falls three cycles after enable, data holds
        enable = 1'b0;
        step(1);
        check_eq("drain1_valid", 32'(out_valid), 32'd1);
        check_eq("drain1_data", 32'(out_data), 32'((k_last - 2) % 256));
        step(1);
        check_eq("drain2_valid", 32'(out_valid), 32'd1);
        check_eq("drain2_data", 32'(out_data), 32'((k_last - 1) % 256));
        step(1);
        check_eq("drain3_valid", 32'(out_valid), 32'd0);
        check_eq("drain3_wrap", 32'(wrap), 32'd0);
        step(3);
        check_eq("hold_data", 32'(out_data), 32'((k_last - 1) % 256));
        check_eq("hold_valid", 32'(out_valid), 32'd0);
        // Resume continues the ramp from the held accumulator
        enable = 1'b1;
        step(1);
        check_eq("resume1_valid", 32'(out_valid), 32'd0);
        step(2);
        check_eq("resume_valid", 32'(out_valid), 32'd1);
        check_eq("resume_data", 32'(out_data), 32'(k_last % 256));
        enable = 1'b0;
        $display("[drain] hold and resume checked");

        // Square, triangle, attenuated saw, reserved code
        run_sweep("square", 1, 8'h40, 0, 512, peak);
        run_sweep("triangle", 2, 8'h80, 0, 512, peak);
        run_sweep("saw_shift2", 3, 8'h80, 2, 256, peak);
        check_eq("saw_shift2_peak", 32'(peak), 32'd63);
        run_sweep("reserved5", 5, 8'h80, 0, 8, peak);

        // Sine at fixed phases
        do_reset();
        load_cfg(1'b1, 3'd0, 16'h0000, 16'h4000, 8'h80, 3'd0);
        enable = 1'b1;
        step(3);
        for (int i = 0; i < 4; i++) begin
            check_eq("sine_q1_data", 32'(out_data), 32'd255);
            check_eq("sine_q1_valid", 32'(out_valid), 32'd1);
            step(1);
        end
        // Attenuation change lands within three cycles, no invalid sample
        load_cfg(1'b0, 3'd0, 16'h0000, 16'h4000, 8'h80, 3'd1);
        for (int i = 0; i < 3; i++) begin
            check_eq("shift_chg_valid", 32'(out_valid), 32'd1);
            step(1);
        end
        check_eq("shift_chg_data", 32'(out_data), 32'd127);
        load_cfg(1'b0, 3'd0, 16'h0000, 16'h0000, 8'h80, 3'd0);
        step(3);
        for (int i = 0; i < 4; i++) begin
            check_eq("sine_zero_data", 32'(out_data), 32'd128);
            step(1);
        end
        load_cfg(1'b0, 3'd0, 16'h0000, 16'hC000, 8'h80, 3'd0);
        step(3);
        check_eq("sine_q3_data", 32'(out_data), 32'd1);
        enable = 1'b0;
        $display("[sine] fixed phases checked");

        // Reset mid-run on the cycle a wrap would otherwise be reported
        do_reset();
        load_cfg(1'b1, 3'd3, 16'h0100, 16'h0000, 8'h80, 3'd0);
        enable = 1'b1;
        step(255);
        rst_n = 1'b0;
        step(1);
        check_eq("midrst_data", 32'(out_data), 32'd0);
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_wrap", 32'(wrap), 32'd0);
        rst_n = 1'b1;
        step(1);
        check_eq("midrst_fill1_valid", 32'(out_valid), 32'd0);
        step(1);
        check_eq("midrst_fill2_valid", 32'(out_valid), 32'd0);
        step(1);
        check_eq("midrst_first_valid", 32'(out_valid), 32'd1);
        check_eq("midrst_first_data", 32'(out_data), 32'd128);
        step(5);
        check_eq("midrst_later_data", 32'(out_data), 32'd128);
        enable = 1'b0;
        $display("[midrst] reset mid-run checked");

        // Noise code
        do_reset();
        load_cfg(1'b1, 3'd4, 16'h0100, 16'h0000, 8'h80, 3'd0);
        enable = 1'b1;
        step(3);
        check_eq("noise_valid", 32'(out_valid), 32'd1);
`ifdef DDS_WAVEGEN_NOISE_EN
        // 16'hACE1 stepped once gives 16'h59C3
        check_eq("noise_data", 32'(out_data), 32'h59);
`else
        check_eq("noise_data", 32'(out_data), 32'd0);
`endif
        enable = 1'b0;
        $display("[noise] first sample checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
        $finish;
    end

endmodule

// File: doc/dds_wavegen.md
DDS_WAVEGEN -- requirements
Module: dds_wavegen

Interface
REQ-001 Parameter DATA_W, default 8, is the sample width of out_data.
REQ-002 Parameter ACC_W, default 16, is the phase accumulator, fword and pword width; ACC_W >= LUT_AW+1 and ACC_W >= DATA_W+1.
REQ-003 Parameter LUT_AW, default 8, is the sine ROM address width (2^LUT_AW entries).
REQ-004 Ports, in this order:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  accumulator advances and samples enter the pipeline while high.
- cfg_load  in  1  one-cycle strobe that latches all cfg_* inputs.
- cfg_clr  in  1  sampled with cfg_load; clears the accumulator to 0.
- cfg_wave  in  3  0 sine, 1 square, 2 triangle, 3 saw, 4 noise (macro), 5-7 reserved.
- cfg_fword  in  ACC_W  frequency word.
- cfg_pword  in  ACC_W  phase offset word.
- cfg_duty  in  8  square high threshold.
- cfg_amp_shift  in  3  attenuation as a right shift.
- out_data  out  DATA_W  sample.
- out_valid  out  1  out_data holds a new sample this cycle.
- wrap  out  1  one-cycle pulse on accumulator overflow.

Function
REQ-005 Config registers load on cfg_load=1 and apply from the next cycle; no accumulator discontinuity unless cfg_clr=1.
REQ-006 When enable=1: acc <= acc + fword, modulo 2^ACC_W; if cfg_load and cfg_clr are both 1, acc <= 0 instead, which takes priority.
REQ-007 wrap SHALL pulse high for the cycle after the addition carries out of bit ACC_W-1; wrap stays 0 while enable=0.
REQ-008 Stage 1: ph <= acc + pword, modulo 2^ACC_W, with a valid bit equal to enable.
REQ-009 Stage 2 computes the waveform from ph:
- Sine: ROM[ph[ACC_W-1 -: LUT_AW]], where ROM[i] = round((2^(DATA_W-1)-1)*sin(2*pi*i/2^LUT_AW)) + 2^(DATA_W-1), offset-binary.
- Square: all-ones if ph[ACC_W-1 -: 8] < cfg_duty, else 0; cfg_duty=0 gives constant 0.
- Triangle: ph[ACC_W-2 -: DATA_W] when ph MSB=0, otherwise its bitwise inverse.
- Saw: ph[ACC_W-1 -: DATA_W].
- Reserved codes: 0.
REQ-010 Stage 3: out_data <= wave >> cfg_amp_shift, logical shift; out_valid <= stage-2 valid.
REQ-011 Latency is exactly 3 cycles: the acc value registered at cycle n appears on out_data at cycle n+3.
REQ-012 When enable=0: acc holds, zero-valid bits drain the pipeline, out_data holds its last value, and out_valid is 0 three cycles after enable falls.
REQ-013 A cfg_wave or cfg_amp_shift change reaches out_data at most 3 cycles after cfg_load, with no invalid intermediate sample.

Reset
REQ-014 When rst_n=0 at a clock edge, the following values are set, and rst_n overrides cfg_load and enable:
- acc=0, pipeline registers 0, out_data=0, out_valid=0, wrap=0.
- cfg_wave=0, cfg_fword=1, cfg_pword=0, cfg_duty=8'h80, cfg_amp_shift=0.
- LFSR=16'hACE1.
REQ-015 A reset mid-run SHALL take effect on the next edge, with no residual samples.

Configuration
REQ-016 The macro DDS_WAVEGEN_NOISE_EN controls the noise mode:
- Defined: cfg_wave=4 selects a 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps once per enabled cycle; stage 2 uses LFSR[15 -: DATA_W].
- Undefined: no LFSR logic exists and cfg_wave=4 outputs 0, like the reserved codes.

Verification (DATA_W=8, ACC_W=16, LUT_AW=8)
REQ-017 Saw, fword=16'h0100, cfg_clr=1, then enable: from cycle 3 out_data=0,1,...,255,0, and wrap pulses every 256 cycles.
REQ-018 Square, duty=8'h40, fword=16'h0100: each 256-sample period has 64 samples of 255 then 192 samples of 0.
REQ-019 Triangle, fword=16'h0100: out_data=0,2,...,254,255,253,...,1, then repeats.
REQ-020 Sine, pword=16'h4000, fword=0: constant 255; with pword=0: constant 128; saw with amp_shift=2 peaks at 63.
REQ-021 rst_n low for 1 cycle mid-run: out_data=0, out_valid=0 and wrap=0 on the next edge; after re-enable, the output is sine at default settings (fword=1) and the first sample is 128.
REQ-022 cfg_wave=4: with DDS_WAVEGEN_NOISE_EN defined, the first valid sample is the top byte of the LFSR after one step from 16'hACE1; undefined, out_data=0.
